// File: rtl/counter_steal_scheduler_pkg.sv
// counter_steal_scheduler_pkg: shared FSM encoding and ones' complement constants
//   state_e      IDLE/READ/MODIFY/WRITE steal sequencer states
//   CTR_BASE_DEF erasable address of counter 0
//   POS_MAX, NEG_MAX, NEG_ZERO, POS_ZERO  15-bit ones' complement landmarks
package counter_steal_scheduler_pkg;
    typedef enum logic [1:0] {IDLE, READ, MODIFY, WRITE} state_e;
    localparam logic [11:0] CTR_BASE_DEF = 12'o24;
    localparam logic [14:0] POS_MAX  = 15'o37777;
    localparam logic [14:0] NEG_MAX  = 15'o40000;
    localparam logic [14:0] NEG_ZERO = 15'o77777;
    localparam logic [14:0] POS_ZERO = 15'o00000;
endpackage

// File: rtl/counter_steal_scheduler_incdec.sv
// counter_steal_scheduler_incdec: 15-bit ones' complement +/-1 with overflow and odd parity
//   v_i      value to update
//   dir_i    1 = +1, 0 = -1
//   res_o    updated value
//   ovf_o    counter wrapped past its positive or negative limit
//   parity_o odd-parity bit for the stored word {res_o, parity_o}
module counter_steal_scheduler_incdec
    import counter_steal_scheduler_pkg::*;
(
    input  logic [14:0] v_i,
    input  logic        dir_i,
    output logic [14:0] res_o,
    output logic        ovf_o,
    output logic        parity_o
);
    // +1 wraps the positive limit to +0 and steps -0 straight to +1 (end-around carry);
    // -1 wraps the negative limit to -0 and steps +0 to -1.
    always_comb begin
        res_o    = dir_i ? (v_i == POS_MAX  ? POS_ZERO :
                            v_i == NEG_ZERO ? 15'o00001 : v_i + 15'd1)
                         : (v_i == NEG_MAX  ? NEG_ZERO :
                            v_i == POS_ZERO ? 15'o77776 : v_i - 15'd1);
        ovf_o    = dir_i ? (v_i == POS_MAX) : (v_i == NEG_MAX);
        parity_o = ~^res_o;
    end
endmodule

// File: rtl/counter_steal_scheduler.sv
// counter_steal_scheduler: cycle-steal read-modify-write servicing of involuntary counters
//   clk, rst       clock, asynchronous active-high reset
//   pinc_req       per-counter +1 request pulses
//   minc_req       per-counter -1 request pulses
//   inst_boundary  a steal may start in this cycle (sampled in IDLE only)
//   steal_active   scheduler owns the memory port
//   mem_addr       counter address while stealing, else 0
//   mem_rd_data    memory word, valid one cycle after mem_addr
//   mem_wr_data    {value, odd parity} during the write cycle, else 0
//   mem_we         one-cycle write strobe per serviced counter
//   ovf_pulse      per-counter overflow, concurrent with mem_we
//   ctr_overrun    sticky: a request hit an already-pending same-direction flag
// Optional feature macro STEAL_BURST_EN: service all pending counters back-to-back
// in one steal instead of one counter per instruction boundary.
module counter_steal_scheduler
    import counter_steal_scheduler_pkg::*;
#(
    parameter int                NUM_CTR  = 8,
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] CTR_BASE = ADDR_W'(CTR_BASE_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CTR-1:0] pinc_req,
    input  logic [NUM_CTR-1:0] minc_req,
    input  logic               inst_boundary,
    output logic               steal_active,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [15:0]        mem_rd_data,
    output logic [15:0]        mem_wr_data,
    output logic               mem_we,
    output logic [NUM_CTR-1:0] ovf_pulse,
    output logic               ctr_overrun
);
    localparam int IDX_W = (NUM_CTR > 1) ? $clog2(NUM_CTR) : 1;
`ifdef STEAL_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [NUM_CTR-1:0] p_q, p_d, m_q, m_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               dir_q, dir_d;
    logic [14:0]        res_q, res_d;
    logic               par_q, par_d;
    logic               ovf_q, ovf_d;
    logic               ovr_q, ovr_d;

    logic [NUM_CTR-1:0] set_p, set_m, clr_p, clr_m;
    logic [IDX_W-1:0]   sel;
    logic               take;
    logic [14:0]        inc_res;
    logic               inc_ovf, inc_par;
    logic               unused_rd_par;

    // Lowest set index wins.
    function automatic logic [IDX_W-1:0] first_set(input logic [NUM_CTR-1:0] f);
        first_set = '0;
        for (int i = NUM_CTR - 1; i >= 0; i--)
            if (f[i]) first_set = IDX_W'(i);
    endfunction

    // The stored parity bit is regenerated, never checked.
    assign unused_rd_par = mem_rd_data[0];

    counter_steal_scheduler_incdec u_incdec (
        .v_i      (mem_rd_data[15:1]),
        .dir_i    (dir_q),
        .res_o    (inc_res),
        .ovf_o    (inc_ovf),
        .parity_o (inc_par)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        res_d   = res_q;
        par_d   = par_q;
        ovf_d   = ovf_q;
        clr_p   = '0;
        clr_m   = '0;
        take    = 1'b0;
        set_p   = pinc_req & ~minc_req;
        set_m   = minc_req & ~pinc_req;
        sel     = first_set(p_q | m_q);
        case (state_q)
            IDLE:   take = |(p_q | m_q) & inst_boundary;
            READ:   state_d = MODIFY;
            MODIFY: begin
                state_d = WRITE;
                res_d   = inc_res;
                par_d   = inc_par;
                ovf_d   = inc_ovf;
            end
            WRITE:  begin
                state_d = IDLE;
                take    = BURST & |(p_q | m_q);
            end
        endcase
        // P wins when both directions are pending; the other flag waits for a later steal.
        if (take) begin
            state_d    = READ;
            idx_d      = sel;
            dir_d      = p_q[sel];
            clr_p[sel] = p_q[sel];
            clr_m[sel] = ~p_q[sel];
        end
        // A new request outranks the clear, so a request for the counter being taken is kept.
        p_d   = (p_q & ~clr_p) | set_p;
        m_d   = (m_q & ~clr_m) | set_m;
        ovr_d = ovr_q | (|((p_q & set_p) | (m_q & set_m)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            m_q     <= '0;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            res_q   <= '0;
            par_q   <= 1'b0;
            ovf_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            m_q     <= m_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            res_q   <= res_d;
            par_q   <= par_d;
            ovf_q   <= ovf_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        steal_active = state_q != IDLE;
        mem_we       = state_q == WRITE;
        mem_addr     = steal_active ? CTR_BASE + ADDR_W'(idx_q) : '0;
        mem_wr_data  = mem_we ? {res_q, par_q} : '0;
        ovf_pulse    = (mem_we && ovf_q) ? NUM_CTR'(1) << idx_q : '0;
        ctr_overrun  = ovr_q;
    end
endmodule
